// File: rtl/rv32im_dmem.sv
// rv32im_dmem: word-organised data RAM behind the LSU, with byte-lane writes,
// read-before-write responses and a configurable wait-state handshake.
module rv32im_dmem #(
  parameter int API_ADDR_WIDTH = 32,
  parameter int API_DATA_WIDTH = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter logic [API_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int WAIT_STATES = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic [API_ADDR_WIDTH-1:0] addr_i,
  input  logic [3:0]                wr_mask_i,
  input  logic [API_DATA_WIDTH-1:0] wr_data_i,
  output logic [API_DATA_WIDTH-1:0] rd_data_o,
  output logic                      ready_o,
  output logic                      busy_o,
  output logic                      err_o
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic [3:0] cnt;
  logic [API_ADDR_WIDTH-1:0] q_addr, a;
  logic [3:0] q_mask, m;
  logic [API_DATA_WIDTH-1:0] q_data, d, wd;
  logic [API_DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [API_ADDR_WIDTH:0] diff;
  logic [IW-1:0] idx;
  logic accept, go, oor, bad, err;
  assign accept = enable_i && state != WAIT;
  // with no wait states the request executes on its own acceptance edge
  assign go = state == WAIT ? cnt == 4'd1 : accept && WAIT_STATES == 0;
  assign a = state == WAIT ? q_addr : addr_i;
  assign m = state == WAIT ? q_mask : wr_mask_i;
  assign d = state == WAIT ? q_data : wr_data_i;
  // a borrow below BASE_ADDR sets the top bit, so one compare covers both range ends
  assign diff = {1'b0, a} - {1'b0, BASE_ADDR};
  assign oor = diff >= (API_ADDR_WIDTH+1)'(4 * DEPTH_WORDS);
  assign idx = diff[IW+1:2];
  always_comb
    case (m)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: bad = 1'b0;
      4'b0011, 4'b1100: bad = a[0];
      4'b1111: bad = a[1:0] != 2'b00;
      default: bad = 1'b1;
    endcase
  assign err = oor || bad;
  assign wd = m == 4'b1111 ? d : (m == 4'b0011 || m == 4'b1100) ? {2{d[15:0]}} : {4{d[7:0]}};
  assign ready_o = state == RESP;
  assign busy_o = state == WAIT;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= IDLE;
      cnt <= '0;
      q_addr <= '0;
      q_mask <= '0;
      q_data <= '0;
      rd_data_o <= '0;
      err_o <= 1'b0;
    end else begin
      if (accept) begin
        q_addr <= addr_i;
        q_mask <= wr_mask_i;
        q_data <= wr_data_i;
      end
      cnt <= state == WAIT ? cnt - 4'd1 : accept ? 4'(WAIT_STATES) : cnt;
      state <= go ? RESP : (accept || state == WAIT) ? WAIT : IDLE;
      err_o <= go && err;
      if (go) rd_data_o <= err ? '0 : mem[idx];
    end
  always_ff @(posedge clk_i)
    if (rst_ni && go && !err)
      for (int b = 0; b < 4; b++)
        if (m[b]) mem[idx][8*b+:8] <= wd[8*b+:8];
endmodule

// File: tb/tb_rv32im_dmem.sv
// tb_rv32im_dmem: two dmem instances (0 and 3 wait states, different bases)
// driven with directed and random traffic, checked against a byte-array model.
module tb_rv32im_dmem;
  localparam int DEPTH = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic        en   [2];
  logic [31:0] addr [2];
  logic [3:0]  mask [2];
  logic [31:0] wdat [2];
  logic [31:0] rd   [2];
  logic        rdy  [2];
  logic        busy [2];
  logic        err  [2];
  logic [7:0]  mem_m [2][4*DEPTH];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv32im_dmem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en[0]), .addr_i(addr[0]), .wr_mask_i(mask[0]),
    .wr_data_i(wdat[0]), .rd_data_o(rd[0]), .ready_o(rdy[0]), .busy_o(busy[0]), .err_o(err[0]));
  rv32im_dmem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h1000), .WAIT_STATES(3)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en[1]), .addr_i(addr[1]), .wr_mask_i(mask[1]),
    .wr_data_i(wdat[1]), .rd_data_o(rd[1]), .ready_o(rdy[1]), .busy_o(busy[1]), .err_o(err[1]));

  function automatic int ws(input int d);
    return d != 0 ? 3 : 0;
  endfunction

  function automatic logic [31:0] base(input int d);
    return d != 0 ? 32'h1000 : 32'h0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte-addressed memory: returns the old aligned word and applies the write.
  function automatic void model(input int d, input logic [31:0] a, input logic [3:0] m,
                                input logic [31:0] wd, output logic [31:0] r, output logic e);
    longint off = longint'(a) - longint'(base(d));
    bit legal;
    int w;
    int lane;
    legal = m == 0 || m == 1 || m == 2 || m == 4 || m == 8 ||
            ((m == 3 || m == 12) && a % 2 == 0) || (m == 15 && a % 4 == 0);
    e = off < 0 || off >= 4 * DEPTH || !legal;
    r = 32'h0;
    if (e) return;
    w = int'(off) / 4 * 4;
    r = {mem_m[d][w+3], mem_m[d][w+2], mem_m[d][w+1], mem_m[d][w]};
    if (m == 15) begin
      for (int i = 0; i < 4; i++) mem_m[d][w+i] = wd[8*i+:8];
    end else if (m == 3 || m == 12) begin
      lane = m == 3 ? 0 : 2;
      mem_m[d][w+lane] = wd[7:0];
      mem_m[d][w+lane+1] = wd[15:8];
    end else if (m != 0) begin
      for (int i = 0; i < 4; i++) if (m == 4'(1 << i)) mem_m[d][w+i] = wd[7:0];
    end
  endfunction

  // Called and returns at a falling edge; one request, bounded wait for ready.
  task automatic xact(input int d, input logic [31:0] a, input logic [3:0] m,
                      input logic [31:0] wd, input bit ck, output logic [31:0] r);
    logic [31:0] er;
    logic ee;
    int n;
    model(d, a, m, wd, er, ee);
    en[d] = 1'b1; addr[d] = a; mask[d] = m; wdat[d] = wd;
    @(negedge clk);
    en[d] = 1'b0;
    n = 1;
    while (!rdy[d] && n <= 8) begin
      check("busy", busy[d], 1);
      @(negedge clk);
      n++;
    end
    r = rd[d];
    check("latency", n, ws(d) + 1);
    check("busy_at_resp", busy[d], 0);
    check("err", err[d], ee);
    if (ck) check("rd", rd[d], er);
    @(negedge clk);
    check("ready_pulse", rdy[d], 0);
    check("err_idle", err[d], 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, er, a;
    logic [3:0] m;
    logic ee;
    int d;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; addr[i] = '0; mask[i] = '0; wdat[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_rd", rd[i], 0);
      check("rst_ready", rdy[i], 0);
      check("rst_busy", busy[i], 0);
      check("rst_err", err[i], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < DEPTH; w++) xact(i, base(i) + 32'(4 * w), 4'hF, $urandom, 0, r);

    model(0, 32'h10, 4'hF, 32'hDEADBEEF, er, ee);
    en[0] = 1'b1; addr[0] = 32'h10; mask[0] = 4'hF; wdat[0] = 32'hDEADBEEF;
    @(negedge clk);
    check("b2b_w_ready", rdy[0], 1);
    check("b2b_w_old", rd[0], er);
    check("b2b_w_err", err[0], 0);
    model(0, 32'h10, 4'h0, 32'h0, er, ee);
    mask[0] = 4'h0; wdat[0] = 32'h0;
    @(negedge clk);
    en[0] = 1'b0;
    check("b2b_r_ready", rdy[0], 1);
    check("b2b_r_new", rd[0], 32'hDEADBEEF);
    check("b2b_r_model", rd[0], er);
    check("b2b_r_err", err[0], 0);
    @(negedge clk);
    check("b2b_idle", rdy[0], 0);

    xact(0, 32'h12, 4'b0100, 32'h000000AA, 1, r);
    xact(0, 32'h10, 4'b0000, 32'h0, 1, r);
    check("byte_lane2", r, 32'hDEAABEEF);
    xact(0, 32'h12, 4'b1100, 32'h00001234, 1, r);
    xact(0, 32'h10, 4'b0000, 32'h0, 1, r);
    check("half_upper", r, 32'h1234BEEF);
    xact(0, 32'(4 * DEPTH), 4'hF, 32'h55555555, 1, r);
    xact(0, 32'h10, 4'b0110, 32'h66666666, 1, r);
    xact(0, 32'h11, 4'b0011, 32'h77777777, 1, r);
    xact(0, 32'h12, 4'b1111, 32'h88888888, 1, r);
    xact(0, 32'h10, 4'b0000, 32'h0, 1, r);
    check("no_write_on_err", r, 32'h1234BEEF);
    xact(0, 32'h0, 4'b0000, 32'h0, 1, r);

    model(1, 32'h1010, 4'h0, 32'h0, er, ee);
    en[1] = 1'b1; addr[1] = 32'h1010; mask[1] = 4'h0; wdat[1] = 32'h0;
    @(negedge clk);
    for (int i = 1; i <= 3; i++) begin
      check("ws_busy", busy[1], 1);
      check("ws_not_ready", rdy[1], 0);
      en[1] = 1'b1; mask[1] = 4'hF; wdat[1] = 32'hBAD0BAD0;
      @(negedge clk);
    end
    en[1] = 1'b0;
    check("ws_ready", rdy[1], 1);
    check("ws_rd", rd[1], er);
    @(negedge clk);
    check("ws_once", rdy[1], 0);
    check("ws_done", busy[1], 0);
    xact(1, 32'h1010, 4'h0, 32'h0, 1, r);

    en[1] = 1'b1; addr[1] = 32'h1020; mask[1] = 4'hF; wdat[1] = 32'h0BADF00D;
    @(negedge clk);
    en[1] = 1'b0;
    check("rst_pre_busy", busy[1], 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy[1], 0);
    check("midrst_ready", rdy[1], 0);
    check("midrst_err", err[1], 0);
    check("midrst_rd", rd[1], 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("postrst_busy", busy[1], 0);
    check("postrst_ready", rdy[1], 0);
    xact(1, 32'h1020, 4'h0, 32'h0, 1, r);

    for (int k = 0; k < 300; k++) begin
      d = int'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 7))
          0: m = 4'b0000; 1: m = 4'b0001; 2: m = 4'b0010; 3: m = 4'b0100;
          4: m = 4'b1000; 5: m = 4'b0011; 6: m = 4'b1100; default: m = 4'b1111;
        endcase
      end else m = 4'($urandom);
      if ($urandom_range(0, 99) < 85) a = base(d) + 32'($urandom_range(0, 4 * DEPTH - 1));
      else case ($urandom_range(0, 3))
        0: a = base(d) - 32'd4;
        1: a = base(d) + 32'(4 * DEPTH);
        2: a = base(d) + 32'(4 * DEPTH + 6);
        default: a = 32'hFFFF_FFFC;
      endcase
      xact(d, a, m, $urandom, 1, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
